// File: rtl/alu_cmd_engine_if.sv
// Command/response bundle for alu_cmd_engine.
//   cmd_*      : command channel (valid/ready), driven by the master
//   rsp_*      : response channel (valid/ready), driven by the slave
//   sticky_ovf : sticky overflow status (slave -> master)
//   clr_sticky : clears sticky_ovf (master -> slave)
interface alu_cmd_engine_if #(
    parameter int SEQ_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic             cmd_cin;
    logic [2:0]       cmd_shift_amt;
    logic             cmd_use_acc;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_res;
    logic             rsp_cout;
    logic             rsp_zero;
    logic             rsp_sign;
    logic             rsp_overflow;
    logic             rsp_err;
    logic [SEQ_W-1:0] rsp_seq;

    logic             sticky_ovf;
    logic             clr_sticky;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin, cmd_shift_amt, cmd_use_acc,
        output rsp_ready, clr_sticky,
        input  cmd_ready,
        input  rsp_valid, rsp_res, rsp_cout, rsp_zero, rsp_sign, rsp_overflow, rsp_err, rsp_seq,
        input  sticky_ovf
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin, cmd_shift_amt, cmd_use_acc,
        input  rsp_ready, clr_sticky,
        output cmd_ready,
        output rsp_valid, rsp_res, rsp_cout, rsp_zero, rsp_sign, rsp_overflow, rsp_err, rsp_seq,
        output sticky_ovf
    );
endinterface

// File: rtl/alu_cmd_engine.sv
// eightbit_alu: combinational 8-bit ALU.
//   opcode    : 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 inc, 7 dec,
//               8 shl, 9 shr, 10 rol, 11 ror (12..15 give zeros)
//   a, b, cin : operands and carry-in (cin used by add only)
//   shift_amt : shift/rotate distance
//   res, cout, overflow : result, carry/borrow out, signed overflow
module eightbit_alu (
    input  logic [3:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [2:0] shift_amt,
    output logic [7:0] res,
    output logic       cout,
    output logic       overflow
);
    logic [8:0]  wide;
    logic [15:0] dbl;

    always_comb begin
        res      = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        wide     = '0;
        dbl      = '0;
        case (opcode)
            4'h0: begin
                wide     = {1'b0, a} + {1'b0, b} + {8'b0, cin};
                res      = wide[7:0];
                cout     = wide[8];
                overflow = (a[7] == b[7]) && (res[7] != a[7]);
            end
            4'h1: begin
                // cout is the borrow out of a - b
                wide     = {1'b0, a} - {1'b0, b};
                res      = wide[7:0];
                cout     = wide[8];
                overflow = (a[7] != b[7]) && (res[7] != a[7]);
            end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = ~a;
            4'h6: begin
                wide     = {1'b0, a} + 9'd1;
                res      = wide[7:0];
                cout     = wide[8];
                overflow = ~a[7] & res[7];
            end
            4'h7: begin
                wide     = {1'b0, a} - 9'd1;
                res      = wide[7:0];
                cout     = wide[8];
                overflow = a[7] & ~res[7];
            end
            4'h8: res = a << shift_amt;
            4'h9: res = a >> shift_amt;
            4'hA: begin
                dbl = {a, a} << shift_amt;
                res = dbl[15:8];
            end
            4'hB: begin
                dbl = {a, a} >> shift_amt;
                res = dbl[7:0];
            end
            default: ;
        endcase
    end
endmodule

// alu_cmd_engine: pipelined command front-end around eightbit_alu.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of alu_cmd_engine_if (command in, response out,
//              sticky overflow status and its clear)
// Stage 1 registers an accepted command; the following edge pushes the
// ALU result into a RSP_DEPTH-entry response FIFO whose head drives rsp_*.
module alu_cmd_engine #(
    parameter int RSP_DEPTH = 4,
    parameter int SEQ_W     = 4
) (
    input logic             clk,
    input logic             rst,
    alu_cmd_engine_if.slave bus
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             err;
        logic             ovf;
        logic             sign;
        logic             zero;
        logic             cout;
        logic [7:0]       res;
        logic [SEQ_W-1:0] seq;
    } rsp_t;

    logic             s1_valid;
    logic [3:0]       s1_opcode;
    logic [7:0]       s1_a;
    logic [7:0]       s1_b;
    logic             s1_cin;
    logic [2:0]       s1_shift;
    logic             s1_use_acc;
    logic [SEQ_W-1:0] s1_seq;

    logic [SEQ_W-1:0] seq_cnt;
    logic [7:0]       acc;
    logic             sticky;

    rsp_t             mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] occupancy;

    logic             accept;
    logic             push;
    logic             pop;
    logic [7:0]       alu_a;
    logic [7:0]       alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    rsp_t             push_ent;
    rsp_t             head;

    // Counting stage 1 in the occupancy guarantees a slot for every accepted
    // command, so the push side never checks for a full FIFO.
    assign occupancy     = count + CNT_W'(s1_valid);
    assign bus.cmd_ready = !rst && (occupancy < CNT_W'(RSP_DEPTH));
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign push          = s1_valid;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    // Accumulator is written on the same edge the next command enters
    // stage 1, so a dependent command reads it with no bypass needed.
    assign alu_a = s1_use_acc ? acc : s1_a;

    eightbit_alu u_alu (
        .opcode    (s1_opcode),
        .a         (alu_a),
        .b         (s1_b),
        .cin       (s1_cin),
        .shift_amt (s1_shift),
        .res       (alu_res),
        .cout      (alu_cout),
        .overflow  (alu_ovf)
    );

    always_comb begin
        push_ent     = '0;
        push_ent.seq = s1_seq;
        if (s1_opcode >= 4'hC) begin
            push_ent.err = 1'b1;
        end else begin
            push_ent.res  = alu_res;
            push_ent.zero = (alu_res == 8'd0);
            push_ent.sign = alu_res[7];
            if (!s1_opcode[3]) begin
                push_ent.cout = alu_cout;
                push_ent.ovf  = alu_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_opcode  <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_cin     <= 1'b0;
            s1_shift   <= '0;
            s1_use_acc <= 1'b0;
            s1_seq     <= '0;
            seq_cnt    <= '0;
            acc        <= '0;
            sticky     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_opcode  <= bus.cmd_opcode;
                s1_a       <= bus.cmd_a;
                s1_b       <= bus.cmd_b;
                s1_cin     <= bus.cmd_cin;
                s1_shift   <= bus.cmd_shift_amt;
                s1_use_acc <= bus.cmd_use_acc;
                s1_seq     <= seq_cnt;
                seq_cnt    <= seq_cnt + SEQ_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (!push_ent.err) begin
                    acc <= push_ent.res;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            // A set on the same edge as a clear takes priority.
            if (push && push_ent.ovf) begin
                sticky <= 1'b1;
            end else if (bus.clr_sticky) begin
                sticky <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    assign head           = bus.rsp_valid ? mem[rd_ptr] : '0;
    assign bus.rsp_valid  = (count != '0);
    assign bus.rsp_res    = head.res;
    assign bus.rsp_cout   = head.cout;
    assign bus.rsp_zero   = head.zero;
    assign bus.rsp_sign   = head.sign;
    assign bus.rsp_overflow = head.ovf;
    assign bus.rsp_err    = head.err;
    assign bus.rsp_seq    = head.seq;
    assign bus.sticky_ovf = sticky;
endmodule

// File: tb/tb_alu_cmd_engine.sv
// Self-checking bench for alu_cmd_engine: directed scenarios plus a random
// stream, checked every cycle against a transaction-level reference model.
module tb_alu_cmd_engine;
    localparam int DEPTH = 4;
    localparam int SW    = 4;

    typedef struct {
        logic [7:0]    res;
        logic          cout;
        logic          zero;
        logic          sign;
        logic          ovf;
        logic          err;
        logic [SW-1:0] seq;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    alu_cmd_engine_if #(.SEQ_W(SW)) bus ();

    alu_cmd_engine #(.RSP_DEPTH(DEPTH), .SEQ_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: commands in order of acceptance.
    exp_t q[$];
    exp_t s1;
    bit   s1v    = 1'b0;
    int   m_acc  = 0;
    int   m_seq  = 0;
    bit   m_sticky = 1'b0;
    exp_t log_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sgn8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    function automatic exp_t model_cmd(input int op, input int a, input int b,
                                       input int cin, input int sh, input int sq);
        exp_t e;
        int   r = 0;
        int   s;
        bit   c = 1'b0;
        bit   v = 1'b0;
        e.err = 1'b0;
        case (op)
            0: begin r = a + b + cin; c = (r > 255); s = sgn8(a) + sgn8(b) + cin; v = (s > 127) || (s < -128); end
            1: begin r = a - b; c = (a < b); s = sgn8(a) - sgn8(b); v = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = a + 1; c = (a == 255); v = (a == 127); end
            7: begin r = a - 1; c = (a == 0); v = (a == 128); end
            8: r = a << sh;
            9: r = a >> sh;
            10: r = (a << sh) | (a >> (8 - sh));
            11: r = (a >> sh) | (a << (8 - sh));
            default: e.err = 1'b1;
        endcase
        r = r & 255;
        e.seq = SW'(sq);
        if (e.err) begin
            e.res = '0; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; e.sign = 1'b0;
        end else begin
            e.res = 8'(r); e.cout = c; e.ovf = v; e.zero = (r == 0); e.sign = (r > 127);
        end
        return e;
    endfunction

    // Compare outputs mid-cycle, then advance the model across the next edge.
    bit   exp_ready;
    bit   do_pop;
    exp_t act;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_cmd_ready", bus.cmd_ready, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_rsp_res", bus.rsp_res, 0);
            check("rst_rsp_flags", {bus.rsp_cout, bus.rsp_zero, bus.rsp_sign, bus.rsp_overflow, bus.rsp_err}, 0);
            check("rst_rsp_seq", bus.rsp_seq, 0);
            check("rst_sticky", bus.sticky_ovf, 0);
            q.delete();
            s1v = 1'b0; m_acc = 0; m_seq = 0; m_sticky = 1'b0;
        end else begin
            exp_ready = (q.size() + int'(s1v)) < DEPTH;
            check("cmd_ready", bus.cmd_ready, exp_ready);
            check("rsp_valid", bus.rsp_valid, q.size() > 0);
            check("sticky_ovf", bus.sticky_ovf, m_sticky);
            if (q.size() > 0) begin
                check("rsp_res", bus.rsp_res, q[0].res);
                check("rsp_cout", bus.rsp_cout, q[0].cout);
                check("rsp_zero", bus.rsp_zero, q[0].zero);
                check("rsp_sign", bus.rsp_sign, q[0].sign);
                check("rsp_overflow", bus.rsp_overflow, q[0].ovf);
                check("rsp_err", bus.rsp_err, q[0].err);
                check("rsp_seq", bus.rsp_seq, q[0].seq);
            end
            do_pop = (q.size() > 0) && bus.rsp_ready;
            if (do_pop) begin
                act.res = bus.rsp_res; act.cout = bus.rsp_cout; act.zero = bus.rsp_zero;
                act.sign = bus.rsp_sign; act.ovf = bus.rsp_overflow; act.err = bus.rsp_err;
                act.seq = bus.rsp_seq;
                log_q.push_back(act);
                void'(q.pop_front());
            end
            if (s1v && s1.ovf) m_sticky = 1'b1;
            else if (bus.clr_sticky) m_sticky = 1'b0;
            if (s1v) q.push_back(s1);
            s1v = bus.cmd_valid && exp_ready;
            if (s1v) begin
                s1 = model_cmd(int'(bus.cmd_opcode), bus.cmd_use_acc ? m_acc : int'(bus.cmd_a),
                               int'(bus.cmd_b), int'(bus.cmd_cin), int'(bus.cmd_shift_amt), m_seq);
                if (!s1.err) m_acc = int'(s1.res);
                m_seq = (m_seq + 1) % (1 << SW);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [2:0] sh, input logic ua);
        bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_cin = cin;
        bus.cmd_shift_amt = sh; bus.cmd_use_acc = ua; bus.cmd_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk);
                #2;
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 1, 0);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #3;
            if (q.size() == 0 && !s1v) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_rsp_valid", bus.rsp_valid, 0);
        check("async_rst_cmd_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #4 rst = 1'b0;
    endtask

    int             acc_cnt;
    logic [31:0]    snap;

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_cin = 1'b0; bus.cmd_shift_amt = '0; bus.cmd_use_acc = 1'b0;
        bus.rsp_ready = 1'b1; bus.clr_sticky = 1'b0;
        #17 rst = 1'b0;

        // Basic ops, back-to-back, consumer always ready
        log_q.delete();
        send(4'h0, 8'd10, 8'd5, 1'b0, 3'd0, 1'b0);
        send(4'h1, 8'd15, 8'd7, 1'b0, 3'd0, 1'b0);
        send(4'h2, 8'd170, 8'd85, 1'b0, 3'd0, 1'b0);
        send(4'h3, 8'd170, 8'd85, 1'b0, 3'd0, 1'b0);
        send(4'h6, 8'd100, 8'd0, 1'b0, 3'd0, 1'b0);
        send(4'h7, 8'd100, 8'd0, 1'b0, 3'd0, 1'b0);
        wait_idle();
        check("basic_count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("add_res", log_q[0].res, 15);
            check("sub_res", log_q[1].res, 8);
            check("and_res", log_q[2].res, 0);
            check("and_zero", log_q[2].zero, 1);
            check("or_res", log_q[3].res, 255);
            check("or_sign", log_q[3].sign, 1);
            check("inc_res", log_q[4].res, 101);
            check("dec_res", log_q[5].res, 99);
            for (int i = 0; i < 6; i++) check("basic_seq", log_q[i].seq, i);
        end

        // Shifts and rotates by one
        log_q.delete();
        for (int op = 8; op < 12; op++) send(4'(op), 8'hAA, 8'h00, 1'b1, 3'd1, 1'b0);
        wait_idle();
        check("shift_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("shl_res", log_q[0].res, 8'h54);
            check("shr_res", log_q[1].res, 8'h55);
            check("rol_res", log_q[2].res, 8'h55);
            check("ror_res", log_q[3].res, 8'h55);
            for (int i = 0; i < 4; i++) check("shift_cout_ovf", {log_q[i].cout, log_q[i].ovf}, 0);
        end

        // Accumulator chaining with an illegal opcode in between
        log_q.delete();
        send(4'h0, 8'd10, 8'd5, 1'b0, 3'd0, 1'b0);
        send(4'hF, 8'd99, 8'd99, 1'b0, 3'd0, 1'b0);
        send(4'h0, 8'd200, 8'd20, 1'b0, 3'd0, 1'b1);
        send(4'h7, 8'd200, 8'd0, 1'b0, 3'd0, 1'b1);
        wait_idle();
        check("chain_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("chain0_res", log_q[0].res, 15);
            check("illegal_err", log_q[1].err, 1);
            check("illegal_res", log_q[1].res, 0);
            check("chain2_res", log_q[2].res, 35);
            check("chain3_res", log_q[3].res, 34);
        end

        // Backpressure: only RSP_DEPTH accepts, head holds, in-order drain
        do_reset();
        log_q.delete();
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.cmd_opcode = 4'h4; bus.cmd_a = 8'h3C; bus.cmd_b = 8'h0F; bus.cmd_use_acc = 1'b0;
        bus.cmd_valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) acc_cnt++;
        end
        check("bp_accepts", acc_cnt, DEPTH);
        check("bp_ready_low", bus.cmd_ready, 0);
        snap = {bus.rsp_valid, bus.rsp_res, bus.rsp_cout, bus.rsp_zero, bus.rsp_sign,
                bus.rsp_overflow, bus.rsp_err, bus.rsp_seq};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_head_stable", {bus.rsp_valid, bus.rsp_res, bus.rsp_cout, bus.rsp_zero,
                  bus.rsp_sign, bus.rsp_overflow, bus.rsp_err, bus.rsp_seq}, snap);
        end
        @(posedge clk);
        #2;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #3;
        check("bp_ready_after_pop", bus.cmd_ready, 1);
        wait_idle();
        check("bp_drain_count", log_q.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < log_q.size(); i++) check("bp_drain_seq", log_q[i].seq, i);

        // Sticky overflow set, clear, and set-wins-over-clear
        log_q.delete();
        send(4'h0, 8'd127, 8'd1, 1'b0, 3'd0, 1'b0);
        wait_idle();
        check("ovf_flag", (log_q.size() > 0) ? log_q[0].ovf : 1'b0, 1);
        check("ovf_sticky_set", bus.sticky_ovf, 1);
        bus.clr_sticky = 1'b1;
        @(posedge clk);
        #2 bus.clr_sticky = 1'b0;
        #1 check("ovf_sticky_clr", bus.sticky_ovf, 0);
        send(4'h0, 8'd127, 8'd1, 1'b0, 3'd0, 1'b0);
        bus.clr_sticky = 1'b1;
        @(posedge clk);
        #2 bus.clr_sticky = 1'b0;
        #1 check("ovf_set_wins", bus.sticky_ovf, 1);
        wait_idle();

        // Reset with three queued responses and stage 1 occupied
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'h0, 8'(i), 8'd3, 1'b0, 3'd0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk);
        #4 rst = 1'b0;
        log_q.delete();
        bus.rsp_ready = 1'b1;
        send(4'h0, 8'd77, 8'd0, 1'b0, 3'd0, 1'b1);
        wait_idle();
        check("post_rst_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("post_rst_acc_res", log_q[0].res, 0);
            check("post_rst_seq", log_q[0].seq, 0);
        end

        // Random traffic with random backpressure and sticky clears
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            bus.cmd_valid     = ($urandom_range(0, 3) != 0);
            bus.cmd_opcode    = 4'($urandom_range(0, 15));
            bus.cmd_a         = 8'($urandom);
            bus.cmd_b         = 8'($urandom);
            bus.cmd_cin       = 1'($urandom);
            bus.cmd_shift_amt = 3'($urandom);
            bus.cmd_use_acc   = 1'($urandom);
            bus.rsp_ready     = ($urandom_range(0, 3) != 0);
            bus.clr_sticky    = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #2;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.clr_sticky = 1'b0;
        wait_idle();
        @(negedge clk);
        check("final_empty", bus.rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
